// File: rtl/ifq_pkg.sv
// Shared fetch-queue widths and entry layout; entries are packed as {pc, instr, err, prdt_taken}.
package ifq_pkg;

  localparam int unsigned MYRISCV_ADDRBUS = 32;
  localparam int unsigned MYRISCV_INSTBUS = 32;

  // Bit positions of the low-order entry fields; pc occupies the top AW bits.
  localparam int unsigned IFQ_PT_BIT    = 0;
  localparam int unsigned IFQ_ERR_BIT   = 1;
  localparam int unsigned IFQ_INSTR_LSB = 2;

  localparam int unsigned IFQ_EW = MYRISCV_ADDRBUS + MYRISCV_INSTBUS + 2;

  function automatic int unsigned ifq_ew(input int unsigned aw, input int unsigned iw);
    return aw + iw + 2;
  endfunction

endpackage

// File: rtl/ifq_ram.sv
// Fetch-queue storage: Depth x Width register file, one write port and one async read port.
module ifq_ram #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 66,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Clearing on reset keeps the idle head (and so the dec_* outputs) at zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue between fetch and decode, flushed on redirect.
// Define IFQ_BYPASS_EN to pass packets straight through to decode when the queue is empty.
module ifq
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = MYRISCV_ADDRBUS,
  parameter int unsigned IW    = MYRISCV_INSTBUS,
  localparam int unsigned PtrW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            ifu_vld_i,
  output logic            ifu_rdy_o,
  input  logic [AW-1:0]   ifu_pc_i,
  input  logic [IW-1:0]   ifu_instr_i,
  input  logic            ifu_err_i,
  input  logic            ifu_prdt_taken_i,
  output logic            dec_vld_o,
  input  logic            dec_rdy_i,
  output logic [AW-1:0]   dec_pc_o,
  output logic [IW-1:0]   dec_instr_o,
  output logic            dec_err_o,
  output logic            dec_prdt_taken_o,
  output logic [PtrW-1:0] ifq_cnt_o
);

  localparam int unsigned AddrW = PtrW - 1;
  localparam int unsigned EW    = ifq_ew(AW, IW);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            empty, full;
  logic            push, pop, wr_en, bypass_take;
  logic [EW-1:0]   wdata, rdata, dec_entry;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign ifu_rdy_o = ~full;
  assign wdata     = {ifu_pc_i, ifu_instr_i, ifu_err_i, ifu_prdt_taken_i};

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass      = empty & ifu_vld_i & ~flush_i;
  assign dec_vld_o   = ~empty | bypass;
  assign dec_entry   = bypass ? wdata : rdata;
  // A bypassed packet taken by decode this cycle never touches storage.
  assign bypass_take = bypass & dec_rdy_i;
`else
  assign dec_vld_o   = ~empty;
  assign dec_entry   = rdata;
  assign bypass_take = 1'b0;
`endif

  assign push  = ifu_vld_i & ifu_rdy_o & ~flush_i;
  assign wr_en = push & ~bypass_take;
  assign pop   = ~empty & dec_rdy_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  ifq_ram #(
    .Depth(DEPTH),
    .Width(EW)
  ) u_ram (
    .clk_i  (clk),
    .rst_ni (rst),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q[AddrW-1:0]),
    .wdata_i(wdata),
    .raddr_i(rd_ptr_q[AddrW-1:0]),
    .rdata_o(rdata)
  );

  assign dec_pc_o         = dec_entry[EW-1 -: AW];
  assign dec_instr_o      = dec_entry[IFQ_INSTR_LSB +: IW];
  assign dec_err_o        = dec_entry[IFQ_ERR_BIT];
  assign dec_prdt_taken_o = dec_entry[IFQ_PT_BIT];
  assign ifq_cnt_o        = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_ifq.sv
// Scoreboard bench for ifq: accepted packets are queued as expectations and checked on delivery.
module tb_ifq;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned PW    = $clog2(DEPTH) + 1;
`ifdef IFQ_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
    logic        pt;
  } pkt_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush_i = 1'b0;
  logic          ifu_vld_i = 1'b0;
  logic          ifu_rdy_o;
  logic [31:0]   ifu_pc_i = '0;
  logic [31:0]   ifu_instr_i = '0;
  logic          ifu_err_i = 1'b0;
  logic          ifu_prdt_taken_i = 1'b0;
  logic          dec_vld_o;
  logic          dec_rdy_i = 1'b0;
  logic [31:0]   dec_pc_o;
  logic [31:0]   dec_instr_o;
  logic          dec_err_o;
  logic          dec_prdt_taken_o;
  logic [PW-1:0] ifq_cnt_o;

  int   n_checks = 0;
  int   n_errors = 0;
  int   mcnt = 0;
  pkt_t exp_q[$];
  logic acc;

  always #5 clk = ~clk;

  ifq #(
    .DEPTH(DEPTH),
    .AW(32),
    .IW(32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .ifu_vld_i       (ifu_vld_i),
    .ifu_rdy_o       (ifu_rdy_o),
    .ifu_pc_i        (ifu_pc_i),
    .ifu_instr_i     (ifu_instr_i),
    .ifu_err_i       (ifu_err_i),
    .ifu_prdt_taken_i(ifu_prdt_taken_i),
    .dec_vld_o       (dec_vld_o),
    .dec_rdy_i       (dec_rdy_i),
    .dec_pc_o        (dec_pc_o),
    .dec_instr_o     (dec_instr_o),
    .dec_err_o       (dec_err_o),
    .dec_prdt_taken_o(dec_prdt_taken_o),
    .ifq_cnt_o       (ifq_cnt_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset(input logic with_flush);
    @(negedge clk);
    rst = 1'b0;
    flush_i = with_flush;
    ifu_vld_i = 1'b0;
    dec_rdy_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    flush_i = 1'b0;
    #1;
    mcnt = 0;
    exp_q.delete();
    check_eq("rst_vld", 64'(dec_vld_o), 64'(0));
    check_eq("rst_rdy", 64'(ifu_rdy_o), 64'(1));
    check_eq("rst_cnt", 64'(ifq_cnt_o), 64'(0));
    check_eq("rst_pc", 64'(dec_pc_o), 64'(0));
    check_eq("rst_instr", 64'(dec_instr_o), 64'(0));
    check_eq("rst_flags", 64'({dec_err_o, dec_prdt_taken_o}), 64'(0));
  endtask

  // One clock: drive inputs, check the cycle against the model, then advance the model.
  task automatic step(input logic vld, input logic [31:0] pc, input logic [31:0] instr,
                      input logic err, input logic pt, input logic drdy, input logic fl,
                      output logic accepted);
    logic exp_vld, deq;
    pkt_t p;
    @(negedge clk);
    ifu_vld_i = vld;
    ifu_pc_i = pc;
    ifu_instr_i = instr;
    ifu_err_i = err;
    ifu_prdt_taken_i = pt;
    dec_rdy_i = drdy;
    flush_i = fl;
    #1;
    exp_vld = (mcnt != 0) || (Bypass && vld && !fl);
    check_eq("ifu_rdy", 64'(ifu_rdy_o), 64'(mcnt != int'(DEPTH)));
    check_eq("cnt", 64'(ifq_cnt_o), 64'(mcnt));
    check_eq("dec_vld", 64'(dec_vld_o), 64'(exp_vld));
    accepted = vld && (mcnt != int'(DEPTH)) && !fl;
    if (accepted) exp_q.push_back('{pc: pc, instr: instr, err: err, pt: pt});
    deq = exp_vld && drdy && !fl;
    if (deq && exp_q.size() > 0) begin
      p = exp_q.pop_front();
      check_eq("dec_pc", 64'(dec_pc_o), 64'(p.pc));
      check_eq("dec_instr", 64'(dec_instr_o), 64'(p.instr));
      check_eq("dec_err", 64'(dec_err_o), 64'(p.err));
      check_eq("dec_pt", 64'(dec_prdt_taken_o), 64'(p.pt));
    end
    if (fl) begin
      mcnt = 0;
      exp_q.delete();
    end else begin
      mcnt = mcnt + int'(accepted) - int'(deq);
    end
  endtask

  task automatic idle(input logic drdy, input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, drdy, 1'b0, a);
  endtask

  initial begin
    int sent;
    int cyc;
    logic [31:0] pc;

    do_reset(1'b0);

    // Single packet through an empty queue.
    step(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    idle(1'b1, 3);

    // Fill with decode stalled; third push must be refused.
    step(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h8000_0004, 32'h0000_0093, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h8000_0008, 32'h0000_0113, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    check_eq("full_refused", 64'(acc), 64'(0));
    idle(1'b0, 1);
    idle(1'b1, 3);

    // Full queue: push refused even though a pop happens in the same cycle.
    step(1'b1, 32'h8000_0010, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h8000_0014, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h8000_0018, 32'h3, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    check_eq("full_pop_push", 64'(acc), 64'(0));
    idle(1'b1, 3);

    // Ten packets with decode ready toggling; retry until each one is accepted.
    sent = 0;
    cyc = 0;
    while (sent < 10 && cyc < 100) begin
      pc = 32'h8000_1000 + 32'(4 * sent);
      step(1'b1, pc, ~pc, 1'b0, sent[0], cyc[0], 1'b0, acc);
      if (acc) sent++;
      cyc++;
    end
    check_eq("stream_sent", 64'(sent), 64'(10));
    idle(1'b1, 4);

    // Flush with a packet offered: it and the queued entries vanish.
    step(1'b1, 32'h8000_0020, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h8000_0024, 32'h6, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h8000_0100, 32'h7, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    idle(1'b1, 1);
    step(1'b1, 32'h8000_0030, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    idle(1'b1, 3);

    // Error/prediction flags stay with their own packet only.
    step(1'b1, 32'h8000_0040, 32'h9, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h8000_0044, 32'hA, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    step(1'b1, 32'h8000_0048, 32'hB, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, 32'h8000_004C, 32'hC, 1'b1, 1'b0, 1'b1, 1'b0, acc);
    idle(1'b1, 4);

    // Empty queue, decode ready: same-cycle delivery when bypass is built in.
    step(1'b1, 32'h8000_0200, 32'hD, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    idle(1'b1, 3);

    // Reset asserted together with flush on a non-empty queue.
    step(1'b1, 32'h8000_0300, 32'hE, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    do_reset(1'b1);
    idle(1'b1, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ifq.md
Name: ifq

Overview:
- Instruction fetch queue between the fetch unit and the decoder.
- Buffers fetched packets of {pc, instr, err, prdt_taken} so a decoder stall does not backpressure the fetch response path in the same cycle.
- Flushes all entries on a redirect (jump/branch-mispredict flush from execute).
- Valid/ready handshake on both sides; in-order, lossless except on flush.

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2
- AW, 32, PC width; matches MYRISCV_ADDRBUS
- IW, 32, instruction width; matches MYRISCV_INSTBUS

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset
- flush_i  input  1  redirect flush; discards all queued and incoming entries
- ifu_vld_i  input  1  fetch packet valid
- ifu_rdy_o  output  1  queue can accept a packet
- ifu_pc_i  input  AW  packet PC
- ifu_instr_i  input  IW  packet instruction
- ifu_err_i  input  1  fetch bus error flag
- ifu_prdt_taken_i  input  1  BPU predicted-taken flag
- dec_vld_o  output  1  head entry valid to decoder
- dec_rdy_i  input  1  decoder accepts head
- dec_pc_o  output  AW  head PC
- dec_instr_o  output  IW  head instruction
- dec_err_o  output  1  head error flag
- dec_prdt_taken_o  output  1  head prediction flag
- ifq_cnt_o  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: DEPTH-entry circular buffer; wr_ptr/rd_ptr each $clog2(DEPTH)+1 bits, MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr)
  - full = MSB differs and lower bits are equal.
- Reset (rst==0 at clock edge):
  - wr_ptr = rd_ptr = 0; ifu_rdy_o = 1; dec_vld_o = 0; ifq_cnt_o = 0.
  - Data outputs reset to 0 (entry 0 cleared).
- Push when ifu_vld_i & ifu_rdy_o & ~flush_i; pop when dec_vld_o & dec_rdy_i & ~flush_i.
- ifu_rdy_o = ~full; no combinational dependence on dec_rdy_i. A push to a full queue is not accepted even if a pop occurs in the same cycle.
- dec_vld_o = ~empty; dec_* outputs are driven by the head entry, mem[rd_ptr].
- Latency: a packet pushed in cycle N is visible at dec_* in cycle N+1.
- Simultaneous push and pop on a non-full, non-empty queue: both pointers advance; count is unchanged.
- Pointer wrap: lower bits wrap mod DEPTH and the MSB toggles. A full-to-empty-to-full sequence across the wrap must preserve order.
- flush_i=1:
  - Next cycle: wr_ptr = rd_ptr = 0, count 0, dec_vld_o = 0.
  - Any handshake in the flush cycle is ignored: no write, no pop credited.
  - ifu_rdy_o stays ~full during the flush cycle; upstream gating of its own valid is upstream's job.
- Flush coincident with reset: reset wins; the result is identical.
- Ordering: entries leave in push order; the err flag travels with its packet. Error packets are never dropped or reordered.
- ifq_cnt_o = wr_ptr - rd_ptr (modular, width as declared).

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined:
  - When the queue is empty, ifu_vld_i=1 and no flush, the input packet drives dec_* combinationally and dec_vld_o = ifu_vld_i.
  - If dec_rdy_i=1 in that cycle, the packet is consumed and not written; otherwise it is written normally.
  - Zero-cycle latency when empty.
- Undefined: strictly registered; 1-cycle minimum latency, with no combinational path from ifu_* to dec_*.

Decomposition:
- Width macros (MYRISCV_ADDRBUS, MYRISCV_INSTBUS) come from mydefines.v.
- Add IFQ_EW = AW+IW+2 (entry width) and the entry field ordering {pc, instr, err, prdt_taken} to the shared defines.
- Storage array plus pointers are naturally a sub-module, ifq_ram (DEPTH x IFQ_EW register file: one write port, one async read port).
- Pointer, flush and handshake logic stay in ifq.

Test Plan:
- Reset, then push pc=0x80000000, instr=0x00000013 with dec_rdy_i=1 -> dec_vld_o=1 the next cycle with the same values; count returns to 0 after the pop.
- Hold dec_rdy_i=0 and push 3 packets (DEPTH=2) -> ifu_rdy_o=0 after the 2nd push, the 3rd is not accepted, count=2; release -> pops 0x80000000 then 0x80000004 in order.
- Continuous push/pop for 10 packets, with dec_rdy_i toggling every cycle -> all 10 PCs delivered in order with no loss; pointers wrap at least twice.
- Queue holding 2 entries; assert flush_i with ifu_vld_i=1 pc=0x80000100 -> next cycle dec_vld_o=0, count=0, 0x80000100 never appears.
- Push with ifu_err_i=1, prdt_taken=1 -> dec_err_o=1 and dec_prdt_taken_o=1 for exactly that entry only.
- With IFQ_BYPASS_EN, empty queue, push pc=0x80000200 with dec_rdy_i=1 -> dec_vld_o=1 in the same cycle and count stays 0.
